// File: rtl/seq_divider_n.sv
// seq_divider_n: multi-cycle restoring divider, one quotient bit per clock.
// Each trial subtraction goes through a single adder_n (divisor inverted,
// carry-in 1); a carry-out of 1 means "no borrow", so the difference is kept.
// Optional feature macro: SEQ_DIV_SIGNED_EN enables two's-complement divide
// when signed_op=1. Without it signed_op is ignored and every divide is
// unsigned. Vectors are [0:BITS-1] with bit 0 as the MSB.
//
// Handshake: start is sampled only while idle (busy=0 and done=0). An accepted
// start latches dividend/divisor on that edge; done pulses for one cycle when
// quotient/remainder/div_by_zero become valid, and they hold until the next
// result is loaded. busy is high from the cycle after accept until done.
// Requests seen while busy or during done are dropped, not queued.

// Plain ripple-free adder: {cout, sum} = a + b + cin.
module adder_n #(
    parameter int BITS = 32
) (
    input  logic [0:BITS-1] a,
    input  logic [0:BITS-1] b,
    input  logic            cin,
    output logic [0:BITS-1] sum,
    output logic            cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cin};
endmodule

module seq_divider_n #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            signed_op,
    input  logic [0:BITS-1] dividend,
    input  logic [0:BITS-1] divisor,
    output logic            busy,
    output logic            done,
    output logic [0:BITS-1] quotient,
    output logic [0:BITS-1] remainder,
    output logic            div_by_zero
);
    localparam int              CW   = $clog2(BITS + 1);
    localparam logic [0:CW-1]   LAST = CW'(BITS - 1);
    localparam logic [0:BITS-1] ONE  = BITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [0:CW-1]   cnt_q;
    logic [0:BITS-1] rem_q;     // partial remainder (magnitude)
    logic [0:BITS-1] dvd_q;     // dividend shifting out, quotient shifting in
    logic [0:BITS-1] dsr_q;     // divisor magnitude
    logic            neg_q_q;   // negate quotient in FIX
    logic            neg_r_q;   // negate remainder in FIX

    logic            accept;
    logic            dsr_zero;
    logic            dvd_neg;
    logic            dsr_neg;
    logic [0:BITS-1] dvd_mag;
    logic [0:BITS-1] dsr_mag;

    // Operand sign handling: only the signed build looks at signed_op.
`ifdef SEQ_DIV_SIGNED_EN
    assign dvd_neg = signed_op & dividend[0];
    assign dsr_neg = signed_op & divisor[0];
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign dvd_neg = 1'b0;
    assign dsr_neg = 1'b0;
`endif

    // Magnitudes as unsigned values; the most-negative value maps to itself,
    // which is already its correct unsigned magnitude.
    assign dvd_mag  = dvd_neg ? (~dividend + ONE) : dividend;
    assign dsr_mag  = dsr_neg ? (~divisor + ONE) : divisor;
    assign dsr_zero = (divisor == '0);
    assign accept   = (state_q == IDLE) && start;

    // Trial subtraction: shifted {rem, next dividend bit} minus divisor,
    // one bit wider than the operands so the shifted remainder never overflows.
    logic [0:BITS]   partial;
    logic [0:BITS]   trial_b;
    logic [0:BITS]   diff;
    logic            no_borrow;
    logic [0:BITS-1] rem_next;

    assign partial = {rem_q, dvd_q[0]};
    assign trial_b = ~{1'b0, dsr_q};

    adder_n #(.BITS(BITS + 1)) u_sub (
        .a    (partial),
        .b    (trial_b),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign rem_next = no_borrow ? diff[1:BITS] : partial[1:BITS];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = dsr_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture, one quotient bit per RUN cycle, sign fix-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (accept) begin
                if (dsr_zero) begin
                    // Zero divisor: answer immediately with the raw dividend.
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end else begin
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    dvd_q   <= dvd_mag;
                    dsr_q   <= dsr_mag;
                    neg_q_q <= dvd_neg ^ dsr_neg;
                    neg_r_q <= dvd_neg;
                end
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CW'(1);
                rem_q <= rem_next;
                dvd_q <= {dvd_q[1:BITS-1], no_borrow};
            end else if (state_q == FIX) begin
                quotient    <= neg_q_q ? (~dvd_q + ONE) : dvd_q;
                remainder   <= neg_r_q ? (~rem_q + ONE) : rem_q;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider_n.sv
// Bench for seq_divider_n: directed cases, randomized divides against an
// arithmetic reference model, ignored start, mid-divide reset, back-to-back.
module tb_seq_divider_n;
    localparam int BITS = 32;
`ifdef SEQ_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic            signed_op;
    logic [BITS-1:0] dividend;
    logic [BITS-1:0] divisor;
    logic            busy;
    logic            done;
    logic [BITS-1:0] quotient;
    logic [BITS-1:0] remainder;
    logic            div_by_zero;

    int checks;
    int errors;

    seq_divider_n #(.BITS(BITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic on the operand values.
    function automatic void model(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                  input logic s, output logic [BITS-1:0] q,
                                  output logic [BITS-1:0] r, output logic dz);
        logic signed [BITS-1:0] sa;
        logic signed [BITS-1:0] sb;
        sa = a;
        sb = b;
        dz = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (SIGNED_EN && s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One divide: pulse start, then check busy/done every cycle, latency,
    // results at done and a hold afterwards. poke>0 re-pulses start in that
    // cycle with other operands, which must be ignored.
    task automatic run_one(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input logic s, input int poke, input string name);
        logic [BITS-1:0] eq, er;
        logic            edz;
        int              exp_lat;
        int              dones;
        model(a, b, s, eq, er, edz);
        exp_lat = (b == 0) ? 1 : BITS + 2;
        dones   = 0;
        @(negedge clk);
        start = 1'b1; signed_op = s; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        for (int k = 1; k <= exp_lat + 2; k++) begin
            @(negedge clk);
            if (k == poke) begin
                start = 1'b1; dividend = $urandom; divisor = $urandom_range(0, 3);
            end
            if (k == poke + 1) start = 1'b0;
            if (done) dones++;
            checks++;
            if (busy !== (k < exp_lat)) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, (k < exp_lat));
            end
            checks++;
            if (done !== (k == exp_lat)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, (k == exp_lat));
            end
            if (k == exp_lat || k == exp_lat + 2) begin
                checks++;
                if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                    errors++;
                    $display("FAIL %s result cycle %0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                             name, k, quotient, remainder, div_by_zero, eq, er, edz);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL %s done count: got %0d want 1", name, dones);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_one(32'd100, 32'd7, 1'b0, -1, "div_100_7");
        run_one(32'hFFFF_FFFF, 32'h1, 1'b0, -1, "max_by_1");
        run_one(32'h0000_F000, 32'h0000_F000, 1'b0, -1, "equal");
        run_one(32'h1234_5678, 32'h0, 1'b0, -1, "div_zero");
        run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, "minneg_by_m1");
        run_one(32'h0, 32'h5, 1'b0, -1, "zero_dividend");
        run_one(32'hFFFF_FFF9, 32'h2, 1'b1, -1, "signed_m7_2");
        // Hand-derived constants for the -7/2 case, independent of the model.
        checks++;
`ifdef SEQ_DIV_SIGNED_EN
        if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL signed_const: got q=%h r=%h want q=fffffffd r=ffffffff", quotient, remainder);
        end
`else
        if (quotient !== 32'h7FFF_FFFC || remainder !== 32'h0000_0001) begin
            errors++;
            $display("FAIL signed_const: got q=%h r=%h want q=7ffffffc r=00000001", quotient, remainder);
        end
`endif
    endtask

    task automatic test_random();
        logic [BITS-1:0] a, b;
        logic            s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2, 3: b = $urandom_range(1, 255);
                4:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            s = 1'($urandom_range(0, 1));
            run_one(a, b, s, -1, "random");
        end
    endtask

    task automatic test_ignore_start();
        run_one(32'd1000, 32'd13, 1'b0, 10, "ignore_start");
        run_one(32'hDEAD_BEEF, 32'h0000_0101, 1'b0, 20, "ignore_start2");
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd5000; divisor = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid abort: got %0d busy/done cycles want 0", seen);
        end
        run_one(32'd5000, 32'd3, 1'b0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] eq, er;
        logic            edz;
        int              got_done;
        run_one(32'd77, 32'd5, 1'b0, -1, "b2b_first");
        // Divide-by-zero answers quickly; start is held through its done cycle.
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'hABCD; divisor = 32'h0;
        @(posedge clk);
        #1;
        divisor = 32'd9; dividend = 32'd12345;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b dz done: got %b want 1", done);
        end
        // start still high during done: must be dropped, then accepted next edge.
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b start in done: got busy=%b want 0", busy);
        end
        @(posedge clk);
        #1 start = 1'b0;
        model(32'd12345, 32'd9, 1'b0, eq, er, edz);
        got_done = 0;
        for (int k = 1; k <= BITS + 3; k++) begin
            @(negedge clk);
            if (done && got_done == 0) begin
                got_done = k;
                checks++;
                if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
                    errors++;
                    $display("FAIL b2b result: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                             quotient, remainder, div_by_zero, eq, er, edz);
                end
            end
        end
        checks++;
        if (got_done != BITS + 2) begin
            errors++;
            $display("FAIL b2b latency: got %0d want %0d", got_done, BITS + 2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
